// File: rtl/lc3_pkg.sv
// Shared LC-3 encodings: opcodes, sequencer states and datapath mux selects.
// The datapath muxes decode the same select constants.
package lc3_pkg;

    localparam logic [3:0] OP_BR  = 4'b0000;
    localparam logic [3:0] OP_ADD = 4'b0001;
    localparam logic [3:0] OP_LD  = 4'b0010;
    localparam logic [3:0] OP_ST  = 4'b0011;
    localparam logic [3:0] OP_AND = 4'b0101;
    localparam logic [3:0] OP_NOT = 4'b1001;
    localparam logic [3:0] OP_JMP = 4'b1100;
    localparam logic [3:0] OP_LEA = 4'b1110;

    typedef enum logic [3:0] {
        S_FETCH0 = 4'd0,
        S_FETCH1 = 4'd1,
        S_FETCH2 = 4'd2,
        S_DECODE = 4'd3,
        S_ALU    = 4'd4,
        S_BR     = 4'd5,
        S_JMP    = 4'd6,
        S_LEA    = 4'd7,
        S_LD0    = 4'd8,
        S_LD1    = 4'd9,
        S_LD2    = 4'd10,
        S_ST0    = 4'd11,
        S_ST1    = 4'd12,
        S_ST2    = 4'd13,
        S_FAULT  = 4'd14
    } state_t;

    localparam logic [1:0] PCMUX_INC  = 2'd0;
    localparam logic [1:0] PCMUX_BUS  = 2'd1;
    localparam logic [1:0] PCMUX_ADDR = 2'd2;

    localparam logic       ADDR1_PC   = 1'b0;
    localparam logic       ADDR1_BASE = 1'b1;

    localparam logic [1:0] ADDR2_ZERO  = 2'd0;
    localparam logic [1:0] ADDR2_OFF6  = 2'd1;
    localparam logic [1:0] ADDR2_OFF9  = 2'd2;
    localparam logic [1:0] ADDR2_OFF11 = 2'd3;

    localparam logic [1:0] ALU_ADD   = 2'd0;
    localparam logic [1:0] ALU_AND   = 2'd1;
    localparam logic [1:0] ALU_NOT   = 2'd2;
    localparam logic [1:0] ALU_PASSA = 2'd3;

endpackage

// File: rtl/lc3_mem_wait_timer.sv
// Counts cycles spent in a memory wait state without mem_ready; flags timeout on
// the cycle the count reaches MEM_WAIT_MAX. A ready in that same cycle suppresses it.
module lc3_mem_wait_timer #(
    parameter int MEM_WAIT_MAX = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic in_wait,
    input  logic mem_ready,
    output logic timeout
);
    localparam int CW = $clog2(MEM_WAIT_MAX + 1);

    logic [CW-1:0] cnt;

    // Held at zero outside wait states, so every wait state is entered with a clear count.
    always_ff @(posedge clk) begin
        if (reset || !in_wait)
            cnt <= '0;
        else if (!mem_ready && cnt != CW'(MEM_WAIT_MAX - 1))
            cnt <= cnt + 1'b1;
    end

    assign timeout = in_wait && !mem_ready && (cnt == CW'(MEM_WAIT_MAX - 1));

endmodule

// File: rtl/lc3_control_fsm.sv
// LC-3 microsequencer: fetch/decode/execute for ADD, AND, NOT, BR, JMP, LD, ST, LEA.
// Outputs are a Moore decode of state; ld_mdr follows mem_ready in the read-wait states.
module lc3_control_fsm
    import lc3_pkg::*;
#(
    parameter int MEM_WAIT_MAX = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] ir,
    input  logic        ben,
    input  logic        mem_ready,
    output logic        ld_mar,
    output logic        ld_mdr,
    output logic        ld_ir,
    output logic        ld_pc,
    output logic        ld_reg,
    output logic        ld_cc,
    output logic        gate_pc,
    output logic        gate_mdr,
    output logic        gate_alu,
    output logic        gate_marmux,
    output logic [1:0]  pcmux_sel,
    output logic        addr1_sel,
    output logic [1:0]  addr2_sel,
    output logic [1:0]  alu_op,
    output logic        mem_en,
    output logic        mem_we,
    output logic        fault,
    output logic [3:0]  state
);
    state_t st, nxt;
    logic   in_wait, timeout;

    assign in_wait = (st == S_FETCH1) || (st == S_LD1) || (st == S_ST2);

    lc3_mem_wait_timer #(.MEM_WAIT_MAX(MEM_WAIT_MAX)) u_timer (
        .clk       (clk),
        .reset     (reset),
        .in_wait   (in_wait),
        .mem_ready (mem_ready),
        .timeout   (timeout)
    );

    always_ff @(posedge clk) begin
        if (reset) st <= S_FETCH0;
        else       st <= nxt;
    end

    assign state = st;

    always_comb begin
        nxt         = st;
        ld_mar      = 1'b0;
        ld_mdr      = 1'b0;
        ld_ir       = 1'b0;
        ld_pc       = 1'b0;
        ld_reg      = 1'b0;
        ld_cc       = 1'b0;
        gate_pc     = 1'b0;
        gate_mdr    = 1'b0;
        gate_alu    = 1'b0;
        gate_marmux = 1'b0;
        pcmux_sel   = PCMUX_INC;
        addr1_sel   = ADDR1_PC;
        addr2_sel   = ADDR2_ZERO;
        alu_op      = ALU_ADD;
        mem_en      = 1'b0;
        mem_we      = 1'b0;
        fault       = 1'b0;
        unique case (st)
            S_FETCH0: begin
                gate_pc = 1'b1; ld_mar = 1'b1; ld_pc = 1'b1;
                nxt = S_FETCH1;
            end
            S_FETCH1: begin
                mem_en = 1'b1; ld_mdr = mem_ready;
                if (mem_ready)    nxt = S_FETCH2;
                else if (timeout) nxt = S_FAULT;
            end
            S_FETCH2: begin
                gate_mdr = 1'b1; ld_ir = 1'b1;
                nxt = S_DECODE;
            end
            S_DECODE: begin
                case (ir[15:12])
                    OP_ADD, OP_AND, OP_NOT: nxt = S_ALU;
                    OP_BR:  nxt = S_BR;
                    OP_JMP: nxt = S_JMP;
                    OP_LD:  nxt = S_LD0;
                    OP_ST:  nxt = S_ST0;
                    OP_LEA: nxt = S_LEA;
                    default: nxt = S_FAULT;
                endcase
            end
            // Operand B (register vs imm5) is picked by the datapath from ir[5].
            S_ALU: begin
                gate_alu = 1'b1; ld_reg = 1'b1; ld_cc = 1'b1;
                case (ir[15:12])
                    OP_AND:  alu_op = ALU_AND;
                    OP_NOT:  alu_op = ALU_NOT;
                    default: alu_op = ALU_ADD;
                endcase
                nxt = S_FETCH0;
            end
            S_BR: begin
                if (ben) begin
                    ld_pc = 1'b1; pcmux_sel = PCMUX_ADDR;
                    addr1_sel = ADDR1_PC; addr2_sel = ADDR2_OFF9;
                end
                nxt = S_FETCH0;
            end
            S_JMP: begin
                ld_pc = 1'b1; pcmux_sel = PCMUX_ADDR;
                addr1_sel = ADDR1_BASE; addr2_sel = ADDR2_ZERO;
                nxt = S_FETCH0;
            end
            S_LEA: begin
                gate_marmux = 1'b1; ld_reg = 1'b1;
                addr1_sel = ADDR1_PC; addr2_sel = ADDR2_OFF9;
                nxt = S_FETCH0;
            end
            S_LD0, S_ST0: begin
                ld_mar = 1'b1; gate_marmux = 1'b1;
                addr1_sel = ADDR1_PC; addr2_sel = ADDR2_OFF9;
                nxt = (st == S_LD0) ? S_LD1 : S_ST1;
            end
            S_LD1: begin
                mem_en = 1'b1; ld_mdr = mem_ready;
                if (mem_ready)    nxt = S_LD2;
                else if (timeout) nxt = S_FAULT;
            end
            S_LD2: begin
                gate_mdr = 1'b1; ld_reg = 1'b1; ld_cc = 1'b1;
                nxt = S_FETCH0;
            end
            S_ST1: begin
                alu_op = ALU_PASSA; gate_alu = 1'b1; ld_mdr = 1'b1;
                nxt = S_ST2;
            end
            S_ST2: begin
                mem_en = 1'b1; mem_we = 1'b1;
                if (mem_ready)    nxt = S_FETCH0;
                else if (timeout) nxt = S_FAULT;
            end
            S_FAULT: fault = 1'b1;
            default: nxt = S_FAULT;
        endcase
        // Reset silences every strobe at once, aborting any memory access in flight.
        if (reset) begin
            ld_mar = 1'b0; ld_mdr = 1'b0; ld_ir = 1'b0; ld_pc = 1'b0;
            ld_reg = 1'b0; ld_cc = 1'b0; gate_pc = 1'b0; gate_mdr = 1'b0;
            gate_alu = 1'b0; gate_marmux = 1'b0; pcmux_sel = PCMUX_INC;
            addr1_sel = ADDR1_PC; addr2_sel = ADDR2_ZERO; alu_op = ALU_ADD;
            mem_en = 1'b0; mem_we = 1'b0; fault = 1'b0;
        end
    end

endmodule
